// File: rtl/rib_rr_arbiter.sv
// Registered round-robin arbiter for the 4-master RIB interconnect, with locked sequences and a hold cap.
// Optional: define RIB_ARB_DBG_PRIO_EN to give master 3 (debug) absolute, fairness-neutral priority.
`ifndef HoldEnable
`define HoldEnable 1'b1
`endif
`ifndef HoldDisable
`define HoldDisable 1'b0
`endif

module rib_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic [3:0] lock_i,
  output logic [1:0] grant_o,
  output logic [3:0] grant_onehot_o,
  output logic       grant_valid_o,
  output logic       hold_flag_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             valid_q, valid_d;

  logic [3:0]       owner_oh;
  logic [3:0]       others;
  logic [2:0]       pick_all;
  logic [2:0]       pick_oth;
  logic [CNT_W-1:0] cnt_inc;

  // Returns {found, index}: first set bit of req searching upward from start, mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + i[1:0];
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign owner_oh = valid_q ? (4'b0001 << grant_q) : 4'b0000;
  assign others   = req_i & ~owner_oh;
  assign pick_all = rr_pick(req_i, ptr_q);
  assign pick_oth = rr_pick(others, ptr_q);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d = OWN;
          valid_d = 1'b1;
          grant_d = pick_all[1:0];
          ptr_d   = pick_all[1:0] + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!req_i[grant_q]) begin
          // Release: hand straight to the next winner so the bus never bubbles.
          if (pick_all[2]) begin
            grant_d = pick_all[1:0];
            ptr_d   = pick_all[1:0] + 2'd1;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else if (lock_i[grant_q]) begin
          cnt_d = cnt_inc;
        end else if ((|others) && (cnt_q == CNT_MAX)) begin
          grant_d = pick_oth[1:0];
          ptr_d   = pick_oth[1:0] + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
`ifdef RIB_ARB_DBG_PRIO_EN
    // Debug master preempts everything; ptr untouched so m0..m2 fairness is preserved.
    if (req_i[3]) begin
      state_d = OWN;
      valid_d = 1'b1;
      grant_d = 2'd3;
      ptr_d   = ptr_q;
      cnt_d   = (valid_q && grant_q == 2'd3) ? cnt_inc : '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o        = grant_q;
  assign grant_valid_o  = valid_q;
  assign grant_onehot_o = owner_oh;
  assign hold_flag_o    = (valid_q && grant_q != 2'd1) ? `HoldEnable : `HoldDisable;

endmodule

// File: doc/rib_rr_arbiter.md
Name: rib_rr_arbiter

Overview:
Registered round-robin arbiter for the 4-master RIB interconnect. It replaces fixed-priority combinational granting with fair, cycle-accurate ownership.
- Supports locked (atomic) multi-cycle sequences.
- A hold counter caps how long one unlocked master can keep the bus.
- Its grant_o drives the interconnect's master-select mux; hold_flag_o stalls the core pipeline while the bus is owned by a non-fetch master.

Parameters:
MAX_HOLD, 16, max consecutive owned cycles for an unlocked owner while others request; legal range 1..2^CNT_W-1
CNT_W, 5, width of the ownership counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_i  input  4  bus request, bit n = master n (m1 = core instruction fetch)
lock_i  input  4  bit n = master n requests atomic ownership; only meaningful with req_i[n]
grant_o  output  2  encoded index of owning master
grant_onehot_o  output  4  one-hot owner; all zero when idle
grant_valid_o  output  1  a master currently owns the bus
hold_flag_o  output  1  `HoldEnable when grant_valid_o && grant_o != 2'd1, else `HoldDisable

Behaviour:
- Reset (async, takes effect immediately, including mid-transaction) clears the following: grant_o=0, grant_onehot_o=0, grant_valid_o=0, hold_flag_o=0, rr pointer ptr=0, cnt=0, state IDLE.
- All outputs come from registers or from registered state only; no combinational path from req_i/lock_i to outputs.
- Latency: a request seen at edge k yields a grant visible after edge k (1 cycle).
- Round-robin pick:
  - Search req_i from ptr upward, mod 4; the first set bit wins.
  - On every new grant to master n: ptr <= (n+1) mod 4, cnt <= 0.
- State IDLE:
  - No request: stay IDLE.
  - Any request: pick winner, go to OWN.
- State OWN (owner o), evaluated each edge, in priority order:
  1. req_i[o]=0: release. If another request is pending, grant the next winner the same edge (no idle bubble); otherwise go to IDLE and clear grant_valid_o/grant_onehot_o. grant_o keeps its last value.
  2. lock_i[o]=1: retain ownership; cnt saturates at MAX_HOLD-1.
  3. Another master requests and cnt==MAX_HOLD-1: forced handover to the round-robin winner among the other masters (o is excluded from the search this edge).
  4. Otherwise retain, cnt <= cnt+1, saturating at MAX_HOLD-1.
- Sole requester: keeps the bus indefinitely, counter saturated, no handover.
- Owner drops req and another master raises req in the same cycle: the other master wins on that edge.
- lock_i bits of non-owners are ignored for arbitration.
- MAX_HOLD=1: unlocked owners yield every cycle whenever contention exists.
- Invariants:
  - grant_onehot_o == (grant_valid_o ? 1<<grant_o : 0) at all times.
  - At most one owner.

Optional Feature:
RIB_ARB_DBG_PRIO_EN:
- Defined: master 3 (debug/JTAG) has absolute priority.
  - req_i[3]=1 preempts any owner on the next edge, regardless of lock_i or cnt.
  - While master 3 owns the bus, no other master is granted.
  - On master 3 release, ptr is left unchanged, so debug access does not perturb fairness among m0..m2.
- Undefined: master 3 participates in round-robin like the others.

Test Plan:
- Reset: assert rst mid-grant with req_i=4'b0101 -> all outputs 0 immediately (before next clk edge); after deassert with req_i=4'b0101 -> grant_o=0 one cycle later, hold_flag_o=1.
- Fairness: req_i=4'b1111 held, lock_i=0, MAX_HOLD=2 -> grant sequence 0,0,1,1,2,2,3,3,0...; hold_flag_o=0 only during master 1 slots.
- Release without bubble: m1 owns, then req_i goes 4'b0010->4'b0100 in one cycle -> grant_o=2 on the next edge, grant_valid_o never drops.
- Lock: m2 owns with lock_i[2]=1, req_i=4'b0111 for 40 cycles -> grant_o stays 2 (exceeds MAX_HOLD=16); lock drops -> handover to m0 on the next edge (ptr=3, m3 not requesting).
- Sole requester / idle: req_i=4'b0001 for 30 cycles -> grant_o=0 throughout; req_i=0 -> grant_valid_o=0, grant_onehot_o=0, hold_flag_o=0 next cycle.
- With RIB_ARB_DBG_PRIO_EN: m0 owns locked, raise req_i[3] -> grant_o=3 next edge; drop req_i[3] with req_i=4'b0011 -> m0 or m1 chosen per the unchanged ptr.
